// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start detection, oversampling edge/bit counters,
// checker/deserializer enables and registered frame-outcome pulses.
module uart_rx_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  PAR_EN,
    input  logic                  strt_glitch,
    input  logic                  par_err,
    input  logic                  stp_err,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [3:0]            bit_cnt,
    output logic                  dat_samp_en,
    output logic                  strt_chk_en,
    output logic                  deser_en,
    output logic                  par_chk_en,
    output logic                  stp_chk_en,
    output logic                  data_valid,
    output logic                  Parity_Error,
    output logic                  Stop_Error
);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e                  r_state, w_state_d;
    logic [PRESCALE_W-1:0]   r_edge_cnt, w_edge_d;
    logic [3:0]              r_bit_cnt, w_bit_d;
    logic [PRESCALE_W-1:0]   r_prescale, w_prescale_d;
    logic                    r_par_en, w_par_en_d;
    logic                    r_data_valid, w_data_valid_d;
    logic                    r_par_err, w_par_err_d;
    logic                    r_stp_err, w_stp_err_d;
    logic                    w_last_edge;

    assign w_last_edge = (r_edge_cnt == r_prescale - PRESCALE_W'(1));

    always_comb begin
        w_state_d      = r_state;
        w_edge_d       = r_edge_cnt;
        w_bit_d        = r_bit_cnt;
        w_prescale_d   = r_prescale;
        w_par_en_d     = r_par_en;
        w_data_valid_d = 1'b0;
        w_par_err_d    = 1'b0;
        w_stp_err_d    = 1'b0;
        strt_chk_en    = 1'b0;
        deser_en       = 1'b0;
        par_chk_en     = 1'b0;
        stp_chk_en     = 1'b0;

        if (r_state != StIdle) begin
            if (w_last_edge) begin
                w_edge_d = '0;
                w_bit_d  = r_bit_cnt + 4'd1;
            end else begin
                w_edge_d = r_edge_cnt + PRESCALE_W'(1);
            end
        end

        case (r_state)
            StIdle: begin
                w_edge_d = '0;
                w_bit_d  = '0;
                // The detection cycle itself is edge 0 of the start bit.
                if (!RX_IN) begin
                    w_state_d    = StStart;
                    w_edge_d     = PRESCALE_W'(1);
                    w_prescale_d = Prescale;
                    w_par_en_d   = PAR_EN;
                end
            end
            StStart: begin
                if (w_last_edge) begin
                    strt_chk_en = 1'b1;
                    if (strt_glitch) begin
                        w_state_d = StIdle;
                        w_edge_d  = '0;
                        w_bit_d   = '0;
                    end else begin
                        w_state_d = StData;
                    end
                end
            end
            StData: begin
                if (w_last_edge) begin
                    deser_en = 1'b1;
                    if (r_bit_cnt == 4'(DATA_WIDTH)) begin
                        w_state_d = r_par_en ? StParity : StStop;
                    end
                end
            end
            StParity: begin
                if (w_last_edge) begin
                    par_chk_en = 1'b1;
                    if (par_err) begin
                        w_state_d   = StIdle;
                        w_edge_d    = '0;
                        w_bit_d     = '0;
                        w_par_err_d = 1'b1;
                    end else begin
                        w_state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (w_last_edge) begin
                    stp_chk_en     = 1'b1;
                    w_state_d      = StIdle;
                    w_edge_d       = '0;
                    w_bit_d        = '0;
                    w_stp_err_d    = stp_err;
                    w_data_valid_d = !stp_err;
                end
            end
            default: begin
                w_state_d = StIdle;
                w_edge_d  = '0;
                w_bit_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= StIdle;
            r_edge_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_prescale   <= '0;
            r_par_en     <= 1'b0;
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_edge_cnt   <= w_edge_d;
            r_bit_cnt    <= w_bit_d;
            r_prescale   <= w_prescale_d;
            r_par_en     <= w_par_en_d;
            r_data_valid <= w_data_valid_d;
            r_par_err    <= w_par_err_d;
            r_stp_err    <= w_stp_err_d;
        end
    end

    assign edge_cnt     = r_edge_cnt;
    assign bit_cnt      = r_bit_cnt;
    assign dat_samp_en  = (r_state != StIdle);
    assign data_valid   = r_data_valid;
    assign Parity_Error = r_par_err;
    assign Stop_Error   = r_stp_err;

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side sequencer for the UART RX path. Detects the falling edge of a start bit on the serial line and runs the oversampling edge/bit counters. Drives the one-cycle enables for the start checker, data sampler, deserializer, parity checker and stop checker, and reads back their combinational verdicts. Issues a `data_valid` pulse for a good frame, or an error pulse when a frame is dropped.

## Interface
- `DATA_WIDTH`, 8: data bits per frame.
- `PRESCALE_W`, 6: width of the prescale input and of the edge counter.
- `CLK` input 1: system clock; all logic on its rising edge.
- `RST` input 1: synchronous, active-high reset.
- `RX_IN` input 1: serial line; idles high.
- `Prescale` input PRESCALE_W: oversampling ratio. Legal values are even, from 8 to 32.
- `PAR_EN` input 1: 1 = frame carries a parity bit.
- `strt_glitch` input 1: start-checker verdict; 1 = start bit was not low.
- `par_err` input 1: parity-checker verdict.
- `stp_err` input 1: stop-checker verdict.
- `edge_cnt` output PRESCALE_W: oversampling edge index inside the current bit.
- `bit_cnt` output 4: frame bit index. Start = 0, data = 1..DATA_WIDTH, parity = DATA_WIDTH+1, stop = last.
- `dat_samp_en` output 1: sampler enable.
- `strt_chk_en` output 1: start-check enable pulse.
- `deser_en` output 1: deserializer shift pulse.
- `par_chk_en` output 1: parity-check enable pulse.
- `stp_chk_en` output 1: stop-check enable pulse.
- `data_valid` output 1: registered pulse; the frame was received cleanly.
- `Parity_Error` output 1: registered pulse; the frame was dropped on a parity error.
- `Stop_Error` output 1: registered pulse; the frame was dropped on a stop error.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- "Last edge" means `edge_cnt == P-1`, where P is the latched prescale.
- IDLE:
  - Counters are held at 0.
  - When `RX_IN == 0`, latch `Prescale` and `PAR_EN`, load `edge_cnt <= 1`, and go to START. The detection cycle counts as edge 0.
- Outside IDLE, `edge_cnt` increments every cycle. On the last edge it wraps to 0 and `bit_cnt` increments.
- START:
  - On the last edge, `strt_chk_en = 1`.
  - If `strt_glitch` is 1, go to IDLE with counters cleared and no error pulse.
  - Otherwise go to DATA.
- DATA:
  - On the last edge of each data bit, `deser_en = 1`.
  - After the last edge of bit DATA_WIDTH, go to PARITY if the latched `PAR_EN` is 1, otherwise to STOP.
- PARITY:
  - On the last edge, `par_chk_en = 1`.
  - If `par_err` is 1, pulse `Parity_Error` and go to IDLE.
  - Otherwise go to STOP.
- STOP:
  - On the last edge, `stp_chk_en = 1`.
  - If `stp_err` is 1, pulse `Stop_Error`; otherwise pulse `data_valid`.
  - Go to IDLE in both cases.
- `dat_samp_en` is 1 in every state except IDLE.
- Checker verdicts are sampled only in the cycle their enable is high. Verdicts at any other time are ignored.
- Changes to `Prescale` or `PAR_EN` during a frame have no effect until the next start detection.
- A low `RX_IN` in the same cycle the FSM returns to IDLE is not a detection. Detection needs IDLE to be the current state.

## Timing
- Enables are combinational decodes of the state and `edge_cnt`. `data_valid`, `Parity_Error` and `Stop_Error` are registered, one cycle wide.
- Reset values: state IDLE, `edge_cnt` 0, `bit_cnt` 0, all pulses 0, all enables 0.
- RST is synchronous and has priority: it aborts any frame on the next edge and produces no pulse.
- Cycle t = 0 is the detection cycle. Bit k occupies cycles k·P to k·P+P-1, and its check or shift enable is at k·P+P-1.
- Frame length N = DATA_WIDTH+2+PAR_EN bits.
  - `stp_chk_en` is at N·P-1.
  - `data_valid` or `Stop_Error` is at N·P.
  - The FSM is in IDLE at N·P, and the earliest next detection is at N·P.

## Test plan
- Clean frame: P=8, PAR_EN=0, byte 0xA5, checkers clean.
  - `strt_chk_en` at t=7.
  - `deser_en` at t=15,23,…,71 (8 pulses).
  - `stp_chk_en` at t=79.
  - `data_valid` high only at t=80; IDLE at t=80.
- Start glitch: P=8, `RX_IN` low for 2 cycles, `strt_glitch=1` at t=7.
  - IDLE at t=8.
  - No `deser_en` and no pulse outputs.
  - `bit_cnt` = 0.
- Parity error: P=16, PAR_EN=1, `par_err=1`.
  - `par_chk_en` at t=159.
  - `Parity_Error` at t=160.
  - No `stp_chk_en`, no `data_valid`.
- Stop error: P=16, PAR_EN=1, `stp_err=1`.
  - `stp_chk_en` at t=175.
  - `Stop_Error` at t=176, with `data_valid` 0.
- Reset mid-frame: RST asserted at t=30 during DATA.
  - Next cycle: all outputs 0 and state IDLE.
  - A following clean frame gives `data_valid` at its own N·P.
- Latching: PAR_EN toggled 0→1 at t=20 of a PAR_EN=0 frame.
  - Frame completes with no `par_chk_en`.
  - A back-to-back frame detected at t=80 uses PAR_EN=1: `par_chk_en` at t=80+79=159 (P=8).
